// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front-end for a single-port byte-masked SRAM macro.
// Optional post-reset zero fill, in-order read response FIFO with credit-based ready.
module sram_req_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 10,
    parameter int WMASK_WIDTH    = 8,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   init_done,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [WMASK_WIDTH-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_din,
    input  logic [DATA_WIDTH-1:0]  mem_dout
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic                  credit;
    logic                  acc;
    logic                  rd_acc;
    logic                  push;
    logic                  pop;

    // Credit counts both queued responses and the read still inside the macro.
    assign credit    = (int'(count_q) + int'(rd_pend_q)) < RSP_DEPTH;
    assign rd_acc    = acc && !req_we;
    assign push      = rd_pend_q;
    assign pop       = (count_q != '0) && rsp_ready;
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = fifo_q[rptr_q];
    assign init_done = init_done_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FSM state, fill counter and init flag registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state and macro pin drive; rstb gating keeps ce/ready low while in reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        acc         = 1'b0;
        req_ready   = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = req_we;
        mem_wmask   = req_wmask;
        mem_addr    = req_addr;
        mem_din     = req_wdata;
        unique case (state_q)
            S_INIT: begin
                mem_ce    = rstb;
                mem_we    = 1'b1;
                mem_wmask = '1;
                mem_addr  = cnt_q;
                mem_din   = '0;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                req_ready   = rstb && credit;
                acc         = req_valid && rstb && credit;
                mem_ce      = acc;
                init_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Read-pending flag and response FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pend_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            rd_pend_q <= rd_acc;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    // Response storage captures the macro's registered read data.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mem_dout;
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed plus random stimulus for sram_req_ctrl,
// checked against a transaction-level memory/response model.
module tb_sram_req_ctrl;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int MW    = 8;
    localparam int RD    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          req_valid, req_ready, req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          mem_ce, mem_we;
    logic [MW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
        .RSP_DEPTH(RD), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    logic [DW-1:0] sram [DEPTH];

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                for (int b = 0; b < MW; b++)
                    if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= sram[mem_addr];
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            stamp;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            k;
    int            checks = 0;
    int            passed = 0;
    int            fails = 0;
    logic          acc_s, pop_s, acc_o, pop_o;
    logic [DW-1:0] pop_dut;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic mi, er, ev;
        @(negedge clk);
        mi = (k < DEPTH);
        er = !mi && (exp_q.size() < RD);
        ev = (exp_q.size() > 0) && (exp_q[0].stamp < k);
        chk("init_done", init_done, !mi);
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) chk("rsp_data", rsp_data, exp_q[0].data);
        if (mi) begin
            chk("init_pins", {mem_ce, mem_we, mem_wmask, mem_din, mem_addr},
                {1'b1, 1'b1, 8'hFF, 64'h0, AW'(k)});
        end else begin
            chk("mem_ce", mem_ce, req_valid && er);
            if (req_valid && er)
                chk("mem_pins", {mem_we, mem_wmask, mem_addr, mem_din},
                    {req_we, req_wmask, req_addr, req_wdata});
        end
        acc_s   = req_valid && er;
        pop_s   = ev && rsp_ready;
        acc_o   = req_valid && req_ready;
        pop_o   = rsp_valid && rsp_ready;
        pop_dut = rsp_data;
        @(posedge clk);
        k++;
        if (pop_s) void'(exp_q.pop_front());
        if (acc_s) begin
            if (req_we) begin
                for (int b = 0; b < MW; b++)
                    if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                exp_q.push_back('{ref_mem[req_addr], k});
            end
        end
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic issue(input logic we, input int a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(a);
        req_wdata = d;
        req_wmask = m;
        n = 0;
        acc_o = 1'b0;
        while (!acc_o && n < 50) begin
            cyc();
            n++;
        end
        if (!acc_o) chk("accept_timeout", 0, 1);
        idle();
    endtask

    task automatic drain();
        int n;
        idle();
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            cyc();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 1100) begin
            cyc();
            n++;
        end
        chk("init_latency", n, DEPTH);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_mem_ce", mem_ce, 0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
        k = 0;
    endtask

    initial begin
        int n, nacc, npop, cur, best;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = {$urandom, $urandom};
            ref_mem[i] = '0;
        end
        mem_dout  = '0;
        rsp_ready = 1'b0;
        idle();
        k = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_init_done", init_done, 0);
        chk("reset_mem_ce", mem_ce, 0);
        rstb = 1'b1;

        wait_init();
        issue(1'b0, 5, '0, '0);
        drain();
        chk("T1_rd5", pop_dut, 0);

        issue(1'b1, 3, 64'h1122334455667788, 8'hFF);
        rsp_ready = 1'b1;
        issue(1'b0, 3, '0, '0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("T2_latency", n + 1, 2);
        drain();
        chk("T2_data", pop_dut, 64'h1122334455667788);

        issue(1'b1, 3, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        issue(1'b0, 3, '0, '0);
        drain();
        chk("T3_data", pop_dut, 64'h11223344BBBBBBBB);

        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(nacc);
            cyc();
            if (acc_o) nacc++;
        end
        idle();
        chk("T4_accepts", nacc, 4);
        chk("T4_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (pop_o) npop++;
        end
        chk("T4_pops", npop, 4);
        chk("T4_ready_back", req_ready, 1);

        rsp_ready = 1'b1;
        nacc = 0;
        npop = 0;
        cur  = 0;
        best = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 16) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_addr  = AW'(i);
            end else begin
                idle();
            end
            cyc();
            if (acc_o) nacc++;
            if (pop_o) begin
                npop++;
                cur++;
                if (cur > best) best = cur;
            end else begin
                cur = 0;
            end
        end
        chk("T6_accepts", nacc, 16);
        chk("T6_pops", npop, 16);
        chk("T6_streak", best, 16);

        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = {$urandom, $urandom};
            req_wmask = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        do_reset();
        repeat (300) cyc();
        do_reset();
        wait_init();

        rsp_ready = 1'b0;
        issue(1'b0, 7, '0, '0);
        issue(1'b0, 8, '0, '0);
        repeat (2) cyc();
        chk("T5_queued", rsp_valid, 1);
        do_reset();
        wait_init();
        issue(1'b1, 9, 64'hDEADBEEF01234567, 8'hF0);
        issue(1'b0, 9, '0, '0);
        drain();
        chk("T5_after", pop_dut, 64'hDEADBEEF00000000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
